// File: rtl/logic_pulse_width_meter_if.sv
// Result port of the pulse-width meter: held width/overflow with a valid/ready handshake.
interface logic_pulse_width_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] WIDTH;
    logic             OVF;
    logic             VALID;
    logic             READY;

    modport master (output WIDTH, output OVF, output VALID, input READY);
    modport slave  (input WIDTH, input OVF, input VALID, output READY);
endinterface

// File: rtl/logic_pulse_width_meter.sv
// Synchronizes an asynchronous pin and measures each active pulse in CLK cycles,
// presenting completed widths on a valid/ready slot with glitch/drop strobes.
//
// state | meaning
// ARM   | waiting for the pin to be inactive before trusting edges; latches polarity
// IDLE  | armed, waiting for a leading edge
// MEAS  | pulse active, counting cycles
module logic_pulse_width_meter #(
    parameter int CNT_W  = 16,
    parameter int MIN_W  = 2,
    parameter int SYNC_N = 2
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             EN,
    input  logic                             POL,
    input  logic                             PIN,
    output logic                             GLITCH,
    output logic                             DROP,
    output logic                             BUSY,
    logic_pulse_width_meter_if.master        res
);

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam int             FILL_W     = $clog2(SYNC_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_W);

    logic [SYNC_N-1:0] sync_q;
    logic [FILL_W-1:0] fill_q;
    logic [1:0]        state;
    logic              pol_r;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic              s;
    logic              s_act;
    logic              pulse_end;
    logic              complete;
    logic              short_end;

    assign s         = sync_q[SYNC_N-1];
    assign s_act     = (s == pol_r);
    assign pulse_end = (state == ST_MEAS) && EN && !s_act;
    assign complete  = pulse_end && (cnt >= MIN_C);
    assign short_end = pulse_end && (cnt < MIN_C);
    assign BUSY      = (state == ST_MEAS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], PIN};
        end
    end

    // The synchronizer's reset zeros are not a real pin level; ARM ignores S until it has refilled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill_q <= FILL_W'(SYNC_N);
        end else if (fill_q != '0) begin
            fill_q <= fill_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_ARM;
            pol_r <= 1'b0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else if (!EN) begin
            state <= ST_ARM;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    if ((fill_q == '0) && (s != POL)) begin
                        pol_r <= POL;
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (s_act) begin
                        state <= ST_MEAS;
                        cnt   <= CNT_ONE;
                        sat   <= (CNT_ONE == CNT_MAX);
                    end
                end
                ST_MEAS: begin
                    if (s_act) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_MAX_M1) begin
                                sat <= 1'b1;
                            end
                        end
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    // A full slot can still take a new result when it is being handed off in the same cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res.WIDTH <= '0;
            res.OVF   <= 1'b0;
            res.VALID <= 1'b0;
            GLITCH    <= 1'b0;
            DROP      <= 1'b0;
        end else begin
            GLITCH <= short_end;
            DROP   <= 1'b0;
            if (complete) begin
                if (!res.VALID || res.READY) begin
                    res.WIDTH <= cnt;
                    res.OVF   <= sat;
                    res.VALID <= 1'b1;
                end else begin
                    DROP <= 1'b1;
                end
            end else if (res.VALID && res.READY) begin
                res.VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_pulse_width_meter.sv
// Directed bench for logic_pulse_width_meter: hand-computed widths, strobes and handshake timing.
module tb_logic_pulse_width_meter;

    logic CLK;
    logic nRST;
    logic en, pol, pin, glitch, drop, busy;
    logic en4, pol4, pin4, glitch4, drop4, busy4;
    int   total;
    int   bad;

    logic_pulse_width_meter_if #(.CNT_W(16)) ifa ();
    logic_pulse_width_meter_if #(.CNT_W(4))  ifb ();

    logic_pulse_width_meter #(.CNT_W(16), .MIN_W(2), .SYNC_N(2)) dut (
        .CLK(CLK), .nRST(nRST), .EN(en), .POL(pol), .PIN(pin),
        .GLITCH(glitch), .DROP(drop), .BUSY(busy), .res(ifa)
    );

    logic_pulse_width_meter #(.CNT_W(4), .MIN_W(2), .SYNC_N(2)) dut4 (
        .CLK(CLK), .nRST(nRST), .EN(en4), .POL(pol4), .PIN(pin4),
        .GLITCH(glitch4), .DROP(drop4), .BUSY(busy4), .res(ifb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST = 1'b0;
        en = 1'b1; pol = 1'b1; pin = 1'b1; ifa.READY = 1'b0;
        en4 = 1'b1; pol4 = 1'b1; pin4 = 1'b0; ifb.READY = 1'b0;
        tick(2);
        chk("rst_width", 32'(ifa.WIDTH), 0);
        chk("rst_ovf", 32'(ifa.OVF), 0);
        chk("rst_valid", 32'(ifa.VALID), 0);
        chk("rst_glitch", 32'(glitch), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_busy", 32'(busy), 0);

        // Pin already high at reset release must not look like a leading edge.
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("arm_busy", 32'(busy), 0);
            chk("arm_valid", 32'(ifa.VALID), 0);
        end
        pin = 1'b0;
        tick(5);
        pin = 1'b1;
        tick(2);
        chk("lead_busy_early", 32'(busy), 0);
        tick(1);
        chk("lead_busy", 32'(busy), 1);
        tick(7);
        pin = 1'b0;
        tick(2);
        chk("w10_valid_early", 32'(ifa.VALID), 0);
        tick(1);
        chk("w10_valid", 32'(ifa.VALID), 1);
        chk("w10_width", 32'(ifa.WIDTH), 10);
        chk("w10_ovf", 32'(ifa.OVF), 0);
        chk("w10_busy_off", 32'(busy), 0);
        ifa.READY = 1'b1;
        tick(1);
        ifa.READY = 1'b0;
        chk("w10_accept", 32'(ifa.VALID), 0);
        chk("w10_width_hold", 32'(ifa.WIDTH), 10);

        // 1-cycle glitch, then a minimum-width pulse.
        pin = 1'b1;
        tick(1);
        pin = 1'b0;
        tick(2);
        chk("glitch_early", 32'(glitch), 0);
        tick(1);
        chk("glitch_strobe", 32'(glitch), 1);
        chk("glitch_no_valid", 32'(ifa.VALID), 0);
        tick(1);
        chk("glitch_one_cycle", 32'(glitch), 0);
        tick(2);
        pin = 1'b1;
        tick(2);
        pin = 1'b0;
        tick(3);
        chk("w2_valid", 32'(ifa.VALID), 1);
        chk("w2_width", 32'(ifa.WIDTH), 2);
        chk("w2_no_glitch", 32'(glitch), 0);
        ifa.READY = 1'b1;
        tick(1);
        ifa.READY = 1'b0;

        // Full slot with READY low: second result dropped.
        pin = 1'b1;
        tick(5);
        pin = 1'b0;
        tick(3);
        chk("w5_width", 32'(ifa.WIDTH), 5);
        pin = 1'b1;
        tick(7);
        pin = 1'b0;
        tick(2);
        chk("drop_early", 32'(drop), 0);
        tick(1);
        chk("drop_strobe", 32'(drop), 1);
        chk("drop_valid_held", 32'(ifa.VALID), 1);
        chk("drop_width_held", 32'(ifa.WIDTH), 5);
        tick(1);
        chk("drop_one_cycle", 32'(drop), 0);
        ifa.READY = 1'b1;
        tick(1);
        ifa.READY = 1'b0;
        chk("drop_accept", 32'(ifa.VALID), 0);

        // Low pulses: re-arm with POL = 0 via EN.
        en = 1'b0; pol = 1'b0; pin = 1'b1;
        tick(2);
        en = 1'b1;
        tick(4);
        pin = 1'b0;
        tick(8);
        pin = 1'b1;
        tick(3);
        chk("low8_valid", 32'(ifa.VALID), 1);
        chk("low8_width", 32'(ifa.WIDTH), 8);
        pin = 1'b0;
        tick(6);
        pin = 1'b1;
        tick(2);
        ifa.READY = 1'b1;
        tick(1);
        ifa.READY = 1'b0;
        chk("same_cycle_valid", 32'(ifa.VALID), 1);
        chk("same_cycle_width", 32'(ifa.WIDTH), 6);
        chk("same_cycle_no_drop", 32'(drop), 0);
        tick(1);
        chk("same_cycle_no_drop2", 32'(drop), 0);
        ifa.READY = 1'b1;
        tick(1);
        ifa.READY = 1'b0;
        chk("low6_accept", 32'(ifa.VALID), 0);

        // Back to high pulses, fill the slot, then reset mid-pulse.
        en = 1'b0; pol = 1'b1; pin = 1'b0;
        tick(2);
        en = 1'b1;
        tick(4);
        pin = 1'b1;
        tick(3);
        pin = 1'b0;
        tick(3);
        chk("w3_width", 32'(ifa.WIDTH), 3);
        pin = 1'b1;
        tick(7);
        chk("mid_busy", 32'(busy), 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_valid", 32'(ifa.VALID), 0);
        chk("async_width", 32'(ifa.WIDTH), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_ovf", 32'(ifa.OVF), 0);
        tick(1);
        nRST = 1'b1;
        tick(6);
        chk("rearm_busy", 32'(busy), 0);
        chk("rearm_valid", 32'(ifa.VALID), 0);
        pin = 1'b0;
        tick(5);
        chk("rearm_no_result", 32'(ifa.VALID), 0);
        pin = 1'b1;
        tick(9);
        pin = 1'b0;
        tick(3);
        chk("w9_valid", 32'(ifa.VALID), 1);
        chk("w9_width", 32'(ifa.WIDTH), 9);
        chk("w9_ovf", 32'(ifa.OVF), 0);

        // Saturation on the 4-bit counter instance.
        tick(2);
        pin4 = 1'b1;
        tick(20);
        pin4 = 1'b0;
        tick(3);
        chk("sat_valid", 32'(ifb.VALID), 1);
        chk("sat_width", 32'(ifb.WIDTH), 15);
        chk("sat_ovf", 32'(ifb.OVF), 1);
        ifb.READY = 1'b1;
        tick(1);
        ifb.READY = 1'b0;
        chk("sat_accept", 32'(ifb.VALID), 0);
        pin4 = 1'b1;
        tick(3);
        pin4 = 1'b0;
        tick(3);
        chk("w3b_valid", 32'(ifb.VALID), 1);
        chk("w3b_width", 32'(ifb.WIDTH), 3);
        chk("w3b_ovf", 32'(ifb.OVF), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_pulse_width_meter.md
# logic_pulse_width_meter

Pulse-width measurement block for the logic-chip emulator: the receiving end of a one-shot output such as a 74HC221 Q/nQ pin. It synchronizes an asynchronous pin and measures each active pulse in CLK cycles. Completed widths are presented on a valid/ready result port, and the block flags glitches, saturation and dropped results. Emulator glue uses it to check one-shot timing and decode pulse-coded signals.

## Interface

- CNT_W, 16, width of the pulse counter and the result.
- MIN_W, 2, minimum accepted width in cycles; shorter pulses are glitches (1 ≤ MIN_W < 2^CNT_W).
- SYNC_N, 2, number of synchronizer flops on PIN (≥ 2).

- CLK  input  1  single clock; all logic on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- EN  input  1  measurement enable.
- POL  input  1  active level measured: 1 = high pulses, 0 = low pulses.
- PIN  input  1  asynchronous pulse input.
- WIDTH  output  CNT_W  measured width of the held result.
- OVF  output  1  held result saturated.
- VALID  output  1  result available.
- READY  input  1  consumer accepts the result.
- GLITCH  output  1  one-cycle strobe: a pulse shorter than MIN_W was rejected.
- DROP  output  1  one-cycle strobe: a completed result was discarded because the slot was full.
- BUSY  output  1  a pulse is being measured.

## Operation

- PIN passes through SYNC_N flops that reset to 0. Call the synchronized value S. S is active when S == pol_r.
- pol_r is a copy of POL, latched on the ARM→IDLE transition. POL changes are ignored until the next ARM.
- FSM states are ARM, IDLE and MEAS.
  - ARM: waits for S to be inactive for POL, latches pol_r, then goes to IDLE. This prevents a false leading edge after reset or enable.
  - IDLE: when S is active, go to MEAS with cnt = 1.
  - MEAS, S still active: cnt increments, saturating at 2^CNT_W−1, and the sat flag sets on reaching the maximum.
  - MEAS, S inactive, cnt < MIN_W: assert GLITCH for 1 cycle, discard the pulse, return to IDLE.
  - MEAS, S inactive, cnt ≥ MIN_W: complete the pulse (cnt, sat) and return to IDLE.
- Result slot:
  - If the slot is empty, or VALID && READY in the same cycle, a completed pulse loads WIDTH = cnt and OVF = sat, and sets VALID.
  - If VALID is high and READY is low, a completed pulse is discarded and DROP is asserted for 1 cycle. The held result is unchanged.
  - VALID && READY with no new completion clears VALID. WIDTH and OVF hold their last values.
- BUSY = (state == MEAS).
- EN = 0 forces ARM and clears cnt and sat; any in-progress pulse is lost silently. The result slot and handshake keep working while EN = 0.
- Asynchronous reset at any time, including mid-pulse, returns everything to reset values immediately.

## Timing

- Reset values: WIDTH = 0, OVF = 0, VALID = 0, GLITCH = 0, DROP = 0, BUSY = 0, state = ARM, cnt = 0, synchronizer = 0.
- Measured width equals the number of CLK cycles S is active. A clean synchronous pulse of N cycles therefore reads N.
- Leading edge on PIN → BUSY high SYNC_N+1 cycles later.
- Trailing edge on PIN → VALID, GLITCH or DROP SYNC_N+1 cycles later.
- Minimum inactive gap between pulses is 1 S-cycle. Back-to-back pulses are each measured.
- VALID stays asserted until accepted. WIDTH and OVF are stable while VALID = 1.
- Handshake completes on any rising edge with VALID && READY.

## Test plan

- Reset with PIN = 1 and POL = 1, hold PIN high for 5 cycles → no BUSY and no VALID. Then PIN low, 10-cycle high pulse, READY = 0 → VALID rises 3 cycles after the falling edge with WIDTH = 10, OVF = 0.
- 1-cycle pulse with MIN_W = 2 → GLITCH for exactly 1 cycle; VALID stays 0. A following 2-cycle pulse gives WIDTH = 2.
- CNT_W = 4, 20-cycle pulse → WIDTH = 15, OVF = 1. A next 3-cycle pulse, after the first result is accepted, gives WIDTH = 3, OVF = 0.
- READY = 0, pulses of 5 then 7 cycles → WIDTH = 5 held and DROP for 1 cycle on the second. Then READY = 1 for 1 cycle → VALID = 0.
- POL = 0, PIN idle high, 8-cycle low pulse → WIDTH = 8. Hold VALID, drive READY = 1 in the exact completion cycle of a 6-cycle pulse → VALID stays 1 and WIDTH = 6, with no DROP.
- Deassert nRST mid-pulse after 4 cycles → all outputs 0 at once. After release with PIN still active, no result until PIN goes inactive (ARM); the next 9-cycle pulse gives WIDTH = 9.
